// File: rtl/ahb_read_master.sv
// AHB-lite read master: fetches COUNT_I consecutive 32-bit words from BASE_I
// using pipelined single NONSEQ transfers, and reports bus errors in a sticky flag.
module ahb_read_master #(
  parameter int AWIDTH = 32,
  parameter int CWIDTH = 8
) (
  input  logic              HCLK_I,
  input  logic              HRESET_I,
  input  logic              START_I,
  input  logic [AWIDTH-1:0] BASE_I,
  input  logic [CWIDTH-1:0] COUNT_I,
  output logic              BUSY_O,
  output logic              DONE_O,
  output logic              ERR_O,
  output logic [AWIDTH-1:0] HADDR_O,
  output logic [1:0]        HTRANS_O,
  output logic              HWRITE_O,
  output logic [2:0]        HSIZE_O,
  input  logic [31:0]       HRDATA_I,
  input  logic              HREADY_I,
  input  logic              HRESP_I,
  output logic [31:0]       DATA_O,
  output logic              DVALID_O
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

  state_e            state_q,  state_d;
  logic [AWIDTH-1:0] haddr_q,  haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [CWIDTH-1:0] left_q,   left_d;    // addresses not yet accepted by the slave
  logic              dphase_q, dphase_d;  // a beat is currently in its data phase
  logic [31:0]       data_q,   data_d;
  logic              dvalid_q, dvalid_d;
  logic              done_q,   done_d;
  logic              err_q,    err_d;

  // Word-aligned increment; wraps naturally modulo 2^AWIDTH.
  function automatic logic [AWIDTH-1:0] next_addr(input logic [AWIDTH-1:0] a);
    return a + AWIDTH'(4);
  endfunction

  always_ff @(posedge HCLK_I) begin
    if (HRESET_I) begin
      state_q  <= S_IDLE;
      haddr_q  <= '0;
      htrans_q <= TRANS_IDLE;
      left_q   <= '0;
      dphase_q <= 1'b0;
      data_q   <= '0;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      left_q   <= left_d;
      dphase_q <= dphase_d;
      data_q   <= data_d;
      dvalid_q <= dvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    left_d   = left_q;
    dphase_d = dphase_q;
    data_d   = data_q;
    dvalid_d = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (START_I) begin
          err_d = 1'b0;
          if (COUNT_I != '0) begin
            haddr_d  = BASE_I & ~AWIDTH'(3);
            htrans_d = TRANS_NONSEQ;
            left_d   = COUNT_I;
            dphase_d = 1'b0;
            state_d  = S_RUN;
          end else begin
            done_d = 1'b0 | 1'b1;
          end
        end
      end

      S_RUN: begin
        if (HREADY_I) begin
          if (dphase_q && HRESP_I) begin
            // Single-cycle error completion: abandon the rest of the job.
            err_d    = 1'b1;
            done_d   = 1'b1;
            htrans_d = TRANS_IDLE;
            dphase_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            if (dphase_q) begin
              data_d   = HRDATA_I;
              dvalid_d = 1'b1;
            end
            if (htrans_q == TRANS_NONSEQ) begin
              dphase_d = 1'b1;
              left_d   = left_q - CWIDTH'(1);
              if (left_q != CWIDTH'(1)) begin
                haddr_d = next_addr(haddr_q);
              end else begin
                htrans_d = TRANS_IDLE;
              end
            end else begin
              // Final data phase finished with no address outstanding.
              dphase_d = 1'b0;
              if (dphase_q) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end
          end
        end else if (dphase_q && HRESP_I) begin
          // First error cycle: withdraw any pending address and wait for completion.
          htrans_d = TRANS_IDLE;
          left_d   = '0;
          state_d  = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (HREADY_I) begin
          err_d    = 1'b1;
          done_d   = 1'b1;
          dphase_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        htrans_d = TRANS_IDLE;
        dphase_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign BUSY_O   = (state_q != S_IDLE);
  assign DONE_O   = done_q;
  assign ERR_O    = err_q;
  assign HADDR_O  = haddr_q;
  assign HTRANS_O = htrans_q;
  assign HWRITE_O = 1'b0;
  assign HSIZE_O  = 3'b010;
  assign DATA_O   = data_q;
  assign DVALID_O = dvalid_q;

endmodule
